// File: rtl/vend_control.sv
// -----------------------------------------------------------------------------
// vend_control
//   Vending-machine control FSM. Takes single-cycle key pulses from the
//   debounce stage, tracks the amount paid, and drives the 7-segment digit
//   data, status LEDs and the beeper trigger. Money is counted in dimes
//   (0.1 yuan).
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   key[2:0]   one-cycle press pulses: [0] insert 0.5, [1] insert 1.0,
//              [2] cancel
//   dout       six BCD digits, [23:20] = leftmost digit5 .. [3:0] = digit0
//   dout_mask  bit i enables digit i
//   led        one-hot state: 0001 IDLE, 0010 COLLECT, 0100 VEND, 1000 REFUND
//   beep_en    one-cycle beep request on entry to VEND or REFUND
// -----------------------------------------------------------------------------
module vend_control #(
  parameter int PRICE     = 25,           // item price, 1..989 dimes
  parameter int COIN_LO   = 5,            // value of key[0]
  parameter int COIN_HI   = 10,           // value of key[1]
  parameter int DISP_TIME = 100_000_000   // cycles the result stays shown
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  key,
  output logic [23:0] dout,
  output logic [5:0]  dout_mask,
  output logic [3:0]  led,
  output logic        beep_en
);

  localparam int TW = $clog2(DISP_TIME + 1);

  localparam logic [9:0]    PRICE_W    = 10'(PRICE);
  localparam logic [9:0]    COIN_LO_W  = 10'(COIN_LO);
  localparam logic [9:0]    COIN_HI_W  = 10'(COIN_HI);
  localparam logic [TW-1:0] TIMER_LAST = TW'(DISP_TIME - 1);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_VEND,
    S_REFUND
  } state_t;

  // Double-dabble: 10-bit binary (0..999) to three BCD digits.
  function automatic logic [11:0] bin2bcd(input logic [9:0] bin);
    logic [21:0] sh;
    sh = {12'd0, bin};
    for (int i = 0; i < 10; i++) begin
      if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
      if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
      if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
      sh = sh << 1;
    end
    return sh[21:10];
  endfunction

  localparam logic [11:0] PRICE_BCD = bin2bcd(PRICE_W);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [9:0]    r_paid;
  logic [9:0]    r_change;
  logic [TW-1:0] r_timer;
  logic          r_beep_pend;   // high in the first cycle of VEND/REFUND

  // ---------------------------------------------------------------------------
  // Key arbitration and datapath
  // ---------------------------------------------------------------------------
  logic       w_cancel;
  logic       w_coin;
  logic [9:0] w_coin_val;
  logic [9:0] w_sum;
  logic       w_pay_done;
  logic       w_timer_done;
  logic [11:0] w_paid_bcd;
  logic [11:0] w_change_bcd;

  // NOTE: every signal gets a value before any conditional assignment, so no
  // path through this block leaves a variable unassigned and no latch appears.
  always_comb begin
    w_cancel   = key[2];
    w_coin     = 1'b0;
    w_coin_val = '0;
    // Cancel beats the 1.0 coin, which beats the 0.5 coin; losers are dropped.
    if (!key[2] && key[1]) begin
      w_coin     = 1'b1;
      w_coin_val = COIN_HI_W;
    end else if (!key[2] && key[0]) begin
      w_coin     = 1'b1;
      w_coin_val = COIN_LO_W;
    end
    w_sum        = r_paid + w_coin_val;
    w_pay_done   = (w_sum >= PRICE_W);
    w_timer_done = (r_timer == TIMER_LAST);
    w_paid_bcd   = bin2bcd(r_paid);
    w_change_bcd = bin2bcd(r_change);
  end

  // ---------------------------------------------------------------------------
  // FSM with registered outputs. The output registers decode the current
  // (pre-update) state, so the display follows the state register by one
  // clock and the beep lines up with the first cycle the result is shown.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register in
  // this block samples the values from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_paid      <= '0;
      r_change    <= '0;
      r_timer     <= '0;
      r_beep_pend <= 1'b0;
      dout        <= {PRICE_BCD, 12'd0};
      dout_mask   <= 6'b111000;
      led         <= 4'b0001;
      beep_en     <= 1'b0;
    end else begin
      r_beep_pend <= 1'b0;

      case (r_state)
        S_IDLE, S_COLLECT: begin
          if (w_cancel) begin
            // Cancel only means something once money has gone in.
            if (r_state == S_COLLECT) begin
              r_change    <= r_paid;
              r_state     <= S_REFUND;
              r_beep_pend <= 1'b1;
            end
          end else if (w_coin) begin
            r_paid <= w_sum;
            if (w_pay_done) begin
              r_change    <= w_sum - PRICE_W;
              r_state     <= S_VEND;
              r_beep_pend <= 1'b1;
            end else begin
              r_state <= S_COLLECT;
            end
          end
        end

        S_VEND, S_REFUND: begin
          // Keys are ignored here, including in the expiry cycle.
          if (w_timer_done) begin
            r_paid   <= '0;
            r_change <= '0;
            r_timer  <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_timer <= r_timer + TIMER_ONE;
          end
        end

        default: r_state <= S_IDLE;
      endcase

      // Output stage
      beep_en <= r_beep_pend;
      case (r_state)
        S_COLLECT: begin
          dout      <= {w_paid_bcd, 12'd0};
          dout_mask <= 6'b111000;
          led       <= 4'b0010;
        end
        S_VEND: begin
          dout      <= {w_paid_bcd, w_change_bcd};
          dout_mask <= 6'b111111;
          led       <= 4'b0100;
        end
        S_REFUND: begin
          dout      <= {w_paid_bcd, w_change_bcd};
          dout_mask <= 6'b111111;
          led       <= 4'b1000;
        end
        default: begin
          dout      <= {PRICE_BCD, 12'd0};
          dout_mask <= 6'b111000;
          led       <= 4'b0001;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_control.sv
// -----------------------------------------------------------------------------
// tb_vend_control
//   Directed, table-driven bench for vend_control with DISP_TIME = 20.
//   Each table row presses one key pattern for one cycle, lets one idle cycle
//   pass, then compares dout / dout_mask / led / beep_en with hand-computed
//   values. Rows flagged 'ride' are followed by a sequence that checks the
//   VEND/REFUND hold time, key immunity and the return to IDLE.
// -----------------------------------------------------------------------------
module tb_vend_control;

  localparam int DISP = 20;

  logic        clk;
  logic        rst;
  logic [2:0]  key;
  logic [23:0] dout;
  logic [5:0]  dout_mask;
  logic [3:0]  led;
  logic        beep_en;

  int n_checks = 0;
  int n_fail   = 0;

  vend_control #(
    .PRICE    (25),
    .COIN_LO  (5),
    .COIN_HI  (10),
    .DISP_TIME(DISP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .dout     (dout),
    .dout_mask(dout_mask),
    .led      (led),
    .beep_en  (beep_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: the directed run is a few hundred cycles.
  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [2:0]  key;
    logic [23:0] dout;
    logic [5:0]  mask;
    logic [3:0]  led;
    logic        beep;
    logic        ride;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [23:0] got,
                       input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [23:0] e_dout,
                            input logic [5:0] e_mask, input logic [3:0] e_led,
                            input logic e_beep);
    check({tag, ".dout"}, dout, e_dout);
    check({tag, ".mask"}, {18'd0, dout_mask}, {18'd0, e_mask});
    check({tag, ".led"},  {20'd0, led},       {20'd0, e_led});
    check({tag, ".beep"}, {23'd0, beep_en},   {23'd0, e_beep});
  endtask

  task automatic check_idle(input string tag);
    check_outs(tag, 24'h025000, 6'b111000, 4'b0001, 1'b0);
  endtask

  // Called at a negedge: key held over one posedge, then one idle posedge,
  // then compare at the following negedge.
  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    key = v.key;
    @(negedge clk);
    key = 3'b000;
    @(negedge clk);
    check_outs(tag, v.dout, v.mask, v.led, v.beep);
  endtask

  // Entered one cycle after the state register reached VEND/REFUND.
  // Outputs must hold through iteration 19 (that posedge is the timer expiry)
  // and read IDLE from iteration 20 on. Keys in VEND/REFUND and in the expiry
  // cycle must not change paid or restart the timer.
  task automatic ride_out(input int idx, input vec_t v);
    for (int i = 1; i <= 21; i++) begin
      case (i)
        5:       key = 3'b111;
        6:       key = 3'b010;
        19:      key = 3'b010;
        default: key = 3'b000;
      endcase
      @(negedge clk);
      key = 3'b000;
      if (i <= 19)
        check_outs($sformatf("ride%0d_hold%0d", idx, i), v.dout, v.mask, v.led, 1'b0);
      else
        check_idle($sformatf("ride%0d_idle%0d", idx, i));
    end
  endtask

  initial begin
    // key         dout        mask       led      beep  ride
    // Plan 2: 1.0 + 1.0 + 0.5 -> exact payment
    vecs[0]  = '{3'b010, 24'h010000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 24'h010000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[2]  = '{3'b010, 24'h020000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 24'h025000, 6'b111111, 4'b0100, 1'b1, 1'b1};
    // Plan 3: 3 x 1.0 -> paid 3.0, change 0.5
    vecs[4]  = '{3'b010, 24'h010000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 24'h020000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[6]  = '{3'b010, 24'h030005, 6'b111111, 4'b0100, 1'b1, 1'b1};
    // Plan 4: cancel in IDLE ignored; 0.5 then cancel -> refund 0.5
    vecs[7]  = '{3'b100, 24'h025000, 6'b111000, 4'b0001, 1'b0, 1'b0};
    vecs[8]  = '{3'b001, 24'h005000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[9]  = '{3'b100, 24'h005005, 6'b111111, 4'b1000, 1'b1, 1'b1};
    // Plan 5: all three keys at once in COLLECT -> cancel wins
    vecs[10] = '{3'b010, 24'h010000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[11] = '{3'b111, 24'h010010, 6'b111111, 4'b1000, 1'b1, 1'b1};
    // key[1] beats key[0] when both pressed
    vecs[12] = '{3'b001, 24'h005000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[13] = '{3'b011, 24'h015000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[14] = '{3'b001, 24'h020000, 6'b111000, 4'b0010, 1'b0, 1'b0};
    vecs[15] = '{3'b001, 24'h025000, 6'b111111, 4'b0100, 1'b1, 1'b1};

    rst = 1'b1;
    key = 3'b000;
    repeat (3) @(negedge clk);
    check_idle("reset_hold");

    // Plan 1: idle display, no beep, for 100 cycles after release.
    rst = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      check_idle($sformatf("idle_quiet%0d", c));
    end

    // Plans 2-5 and priority cases.
    for (int n = 0; n < NV; n++) begin
      apply_vec(n, vecs[n]);
      if (vecs[n].ride) ride_out(n, vecs[n]);
    end

    // Plan 6: reset half-way through VEND.
    apply_vec(0, vecs[0]);
    apply_vec(2, vecs[2]);
    apply_vec(3, vecs[3]);      // timer = 1 here
    repeat (DISP / 2 - 1) @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle("rst_mid_vend");
    @(negedge clk);
    rst = 1'b0;
    check_idle("rst_mid_vend_release");
    apply_vec(0, vecs[0]);      // coins accepted again

    // Reset while a refund beep is pending: the beep must never appear.
    key = 3'b100;
    @(negedge clk);
    key = 3'b000;
    rst = 1'b1;
    #1;
    check_idle("rst_beep_pend");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_idle($sformatf("rst_beep_drop%0d", c));
    end
    apply_vec(8, vecs[8]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
